// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : alu_sequencer_pkg                                             |
// | Description : Shared state encoding, local opcodes and instruction fields   |
// |               for the alu8 control sequencer.                               |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package alu_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_F0    = 3'd1,
      ST_L0    = 3'd2,
      ST_L1    = 3'd3,
      ST_ISSUE = 3'd4,
      ST_WAIT  = 3'd5,
      ST_WB    = 3'd6,
      ST_HALT  = 3'd7
   } state_t;

   localparam logic [7:0] OP_HALT     = 8'hFF;
   localparam logic [7:0] OP_LDI_BASE = 8'hF0;

   // byte1 layout: {dst, lhs, rhs, 2'b00}
   localparam int FIELD_W = 2;
   localparam int DST_LSB = 6;
   localparam int LHS_LSB = 4;
   localparam int RHS_LSB = 2;

endpackage : alu_sequencer_pkg
`default_nettype wire

// File: rtl/alu_sequencer_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : alu_sequencer_regfile                                         |
// | Description : 4x8 register file, two async operand ports, one async debug   |
// |               port and one synchronous write port with synchronous reset.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module alu_sequencer_regfile (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] rd_a_sel,
   output logic [7:0] rd_a_data,
   input  logic [1:0] rd_b_sel,
   output logic [7:0] rd_b_data,
   input  logic [1:0] dbg_sel,
   output logic [7:0] dbg_data,
   input  logic       wr_en,
   input  logic [1:0] wr_sel,
   input  logic [7:0] wr_data
);

   logic [7:0] regs_q [4];
   logic [7:0] regs_d [4];

   // Reads see regs_q, so a same-cycle write is only visible after the edge.
   assign rd_a_data = regs_q[rd_a_sel];
   assign rd_b_data = regs_q[rd_b_sel];
   assign dbg_data  = regs_q[dbg_sel];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_en) begin
         regs_d[wr_sel] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule : alu_sequencer_regfile
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : alu_sequencer                                                 |
// | Description : Fetches 2-byte instructions from a synchronous ROM, issues    |
// |               ALU ops to alu8 and writes results back; runs LDI/HALT local. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int ALU_LAT = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [PC_W-1:0] prog_addr,
   input  logic [7:0]      prog_data,
   output logic            alu_enable,
   output logic [7:0]      alu_opcode,
   output logic [7:0]      alu_lhs,
   output logic [7:0]      alu_rhs,
   input  logic [7:0]      alu_result,
   output logic            busy,
   output logic            halted,
   input  logic [1:0]      dbg_sel,
   output logic [7:0]      dbg_data
);

   localparam int CNT_W = (ALU_LAT > 2) ? $clog2(ALU_LAT) : 1;

   state_t           state_q,      state_d;
   logic [PC_W-1:0]  pc_q,         pc_d;
   logic [PC_W-1:0]  prog_addr_q,  prog_addr_d;
   logic [7:0]       byte0_q,      byte0_d;
   logic [1:0]       dst_q,        dst_d;
   logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
   logic             alu_enable_q, alu_enable_d;
   logic [7:0]       alu_opcode_q, alu_opcode_d;
   logic [7:0]       alu_lhs_q,    alu_lhs_d;
   logic [7:0]       alu_rhs_q,    alu_rhs_d;
   logic             busy_q,       busy_d;
   logic             halted_q,     halted_d;

   logic [7:0]       rd_lhs;
   logic [7:0]       rd_rhs;
   logic             is_ldi;
   logic             rf_wr_en;
   logic [1:0]       rf_wr_sel;
   logic [7:0]       rf_wr_data;

   assign is_ldi = (byte0_q[7:2] == OP_LDI_BASE[7:2]);

   // Operand selects come straight off prog_data in L1 so operands are
   // captured on the L1->ISSUE edge, before any writeback of this op.
   alu_sequencer_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_a_sel  (prog_data[LHS_LSB +: FIELD_W]),
      .rd_a_data (rd_lhs),
      .rd_b_sel  (prog_data[RHS_LSB +: FIELD_W]),
      .rd_b_data (rd_rhs),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data),
      .wr_en     (rf_wr_en),
      .wr_sel    (rf_wr_sel),
      .wr_data   (rf_wr_data)
   );

   always_comb begin
      rf_wr_en   = 1'b0;
      rf_wr_sel  = byte0_q[1:0];
      rf_wr_data = prog_data;
      if (state_q == ST_L1 && is_ldi && byte0_q != OP_HALT) begin
         rf_wr_en = 1'b1;
      end else if (state_q == ST_WB) begin
         rf_wr_en   = 1'b1;
         rf_wr_sel  = dst_q;
         rf_wr_data = alu_result;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      prog_addr_d  = prog_addr_q;
      byte0_d      = byte0_q;
      dst_d        = dst_q;
      wait_cnt_d   = wait_cnt_q;
      alu_enable_d = 1'b0;
      alu_opcode_d = alu_opcode_q;
      alu_lhs_d    = alu_lhs_q;
      alu_rhs_d    = alu_rhs_q;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_F0;
               pc_d    = '0;
            end
         end
         ST_F0: begin
            state_d = ST_L0;
         end
         ST_L0: begin
            byte0_d = prog_data;
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_L1;
         end
         ST_L1: begin
            dst_d = prog_data[DST_LSB +: FIELD_W];
            pc_d  = pc_q + PC_W'(1);
            if (byte0_q == OP_HALT) begin
               state_d = ST_HALT;
            end else if (is_ldi) begin
               state_d = ST_F0;
            end else begin
               state_d      = ST_ISSUE;
               alu_enable_d = 1'b1;
               alu_opcode_d = byte0_q;
               alu_lhs_d    = rd_lhs;
               alu_rhs_d    = rd_rhs;
            end
         end
         ST_ISSUE: begin
            state_d    = ST_WAIT;
            wait_cnt_d = CNT_W'(ALU_LAT - 2);
         end
         ST_WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = ST_WB;
            end else begin
               wait_cnt_d = wait_cnt_q - CNT_W'(1);
            end
         end
         ST_WB: begin
            state_d = ST_F0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // ROM address leads the byte capture by one clock: pc in F0, pc+1 in L0.
      if (state_d == ST_F0) begin
         prog_addr_d = pc_d;
      end else if (state_d == ST_L0) begin
         prog_addr_d = pc_d + PC_W'(1);
      end

      busy_d   = !(state_d == ST_IDLE || state_d == ST_HALT);
      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         prog_addr_q  <= '0;
         byte0_q      <= 8'h00;
         dst_q        <= 2'b00;
         wait_cnt_q   <= '0;
         alu_enable_q <= 1'b0;
         alu_opcode_q <= 8'h00;
         alu_lhs_q    <= 8'h00;
         alu_rhs_q    <= 8'h00;
         busy_q       <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         prog_addr_q  <= prog_addr_d;
         byte0_q      <= byte0_d;
         dst_q        <= dst_d;
         wait_cnt_q   <= wait_cnt_d;
         alu_enable_q <= alu_enable_d;
         alu_opcode_q <= alu_opcode_d;
         alu_lhs_q    <= alu_lhs_d;
         alu_rhs_q    <= alu_rhs_d;
         busy_q       <= busy_d;
         halted_q     <= halted_d;
      end
   end

   assign prog_addr  = prog_addr_q;
   assign alu_enable = alu_enable_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_lhs    = alu_lhs_q;
   assign alu_rhs    = alu_rhs_q;
   assign busy       = busy_q;
   assign halted     = halted_q;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_alu_sequencer                                              |
// | Description : Scoreboard bench: ROM and alu8 models, directed programs.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_alu_sequencer;

   typedef struct {
      logic [7:0] op;
      logic [7:0] lhs;
      logic [7:0] rhs;
      logic       chk;
      logic [7:0] old_v;
      logic [7:0] new_v;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic       start2;
   logic [7:0] prog_addr,  prog_data;
   logic [1:0] prog_addr2;
   logic [7:0] prog_data2;
   logic       alu_enable, alu_enable2;
   logic [7:0] alu_opcode, alu_lhs, alu_rhs, alu_result;
   logic [7:0] alu_opcode2, alu_lhs2, alu_rhs2, alu_result2;
   logic       busy, halted, busy2, halted2;
   logic [1:0] dbg_sel, dbg_sel2;
   logic [7:0] dbg_data, dbg_data2;

   logic [7:0] rom1 [256];
   logic [7:0] rom2 [4];
   exp_t       sbq [$];
   int         n_tot  = 0;
   int         n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alu_sequencer #(.PC_W(8), .ALU_LAT(2)) dut (
      .clk(clk), .rst(rst), .start(start),
      .prog_addr(prog_addr), .prog_data(prog_data),
      .alu_enable(alu_enable), .alu_opcode(alu_opcode),
      .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_result(alu_result),
      .busy(busy), .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   alu_sequencer #(.PC_W(2), .ALU_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .prog_addr(prog_addr2), .prog_data(prog_data2),
      .alu_enable(alu_enable2), .alu_opcode(alu_opcode2),
      .alu_lhs(alu_lhs2), .alu_rhs(alu_rhs2), .alu_result(alu_result2),
      .busy(busy2), .halted(halted2), .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
   );

   // Synchronous ROMs: data for an address appears one clock later.
   always @(posedge clk) begin
      prog_data  <= rom1[prog_addr];
      prog_data2 <= rom2[prog_addr2];
   end

   // alu8 model: 00 pass lhs, 01 pass rhs, 02 add; result valid 2 clocks after enable.
   function automatic logic [7:0] alu_f(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         8'h00:   return a;
         8'h01:   return b;
         8'h02:   return a + b;
         default: return a ^ b;
      endcase
   endfunction

   logic       s1v = 1'b0, s2v = 1'b0, t1v = 1'b0, t2v = 1'b0;
   logic [7:0] s1r = 8'h00, s2r = 8'h00, t1r = 8'h00, t2r = 8'h00;
   always @(posedge clk) begin
      s1v <= alu_enable;  s1r <= alu_f(alu_opcode, alu_lhs, alu_rhs);
      s2v <= s1v;         s2r <= s1r;
      t1v <= alu_enable2; t1r <= alu_f(alu_opcode2, alu_lhs2, alu_rhs2);
      t2v <= t1v;         t2r <= t1r;
   end
   assign alu_result  = s2v ? s2r : 8'hEE;
   assign alu_result2 = t2v ? t2r : 8'hEE;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: every enable pulse pops one expected issue and follows it to WB+1.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (alu_enable === 1'b1) begin
            if (sbq.size() == 0) begin
               n_tot++;
               $display("FAIL unexpected_issue: got opcode %h expected no issue", alu_opcode);
            end else begin
               e = sbq.pop_front();
               check8("issue_opcode", alu_opcode, e.op);
               check8("issue_lhs", alu_lhs, e.lhs);
               check8("issue_rhs", alu_rhs, e.rhs);
               @(negedge clk);
               check8("enable_width", {7'b0, alu_enable}, 8'h00);
               check8("opcode_stable_wait", alu_opcode, e.op);
               @(negedge clk);
               if (busy) begin
                  check8("opcode_stable_wb", alu_opcode, e.op);
                  check8("rhs_stable_wb", alu_rhs, e.rhs);
                  if (e.chk) check8("dbg_old_during_wb", dbg_data, e.old_v);
               end
               @(negedge clk);
               if (busy && e.chk) check8("dbg_after_wb", dbg_data, e.new_v);
            end
         end
      end
   end

   task automatic load_prog(input int sel);
      for (int i = 0; i < 256; i++) rom1[i] = 8'hFF;
      case (sel)
         0: begin // r0=5, r1=3, r2=r0+r1, halt
            rom1[0] = 8'hF0; rom1[1] = 8'h05; rom1[2] = 8'hF1; rom1[3] = 8'h03;
            rom1[4] = 8'h02; rom1[5] = 8'h84; rom1[6] = 8'hFF; rom1[7] = 8'h00;
         end
         1: begin // r0=FF, r1=02, r0=r0+r1, halt
            rom1[0] = 8'hF0; rom1[1] = 8'hFF; rom1[2] = 8'hF1; rom1[3] = 8'h02;
            rom1[4] = 8'h02; rom1[5] = 8'h04; rom1[6] = 8'hFF; rom1[7] = 8'h00;
         end
         default: begin // r0=AA, r1=55, r3=pass lhs, r2=pass rhs, halt
            rom1[0] = 8'hF0; rom1[1] = 8'hAA; rom1[2] = 8'hF1; rom1[3] = 8'h55;
            rom1[4] = 8'h00; rom1[5] = 8'hC4; rom1[6] = 8'h01; rom1[7] = 8'h84;
            rom1[8] = 8'hFF; rom1[9] = 8'h00;
         end
      endcase
   endtask

   task automatic read_reg(input logic [1:0] s, output logic [7:0] v);
      dbg_sel = s;
      #1 v = dbg_data;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] v;
      read_reg(2'd0, v); check8({tag, "_r0"}, v, e0);
      read_reg(2'd1, v); check8({tag, "_r1"}, v, e1);
      read_reg(2'd2, v); check8({tag, "_r2"}, v, e2);
      read_reg(2'd3, v); check8({tag, "_r3"}, v, e3);
   endtask

   task automatic check_idle_outputs(input string tag);
      check8({tag, "_prog_addr"}, prog_addr, 8'h00);
      check8({tag, "_alu_enable"}, {7'b0, alu_enable}, 8'h00);
      check8({tag, "_alu_opcode"}, alu_opcode, 8'h00);
      check8({tag, "_alu_lhs"}, alu_lhs, 8'h00);
      check8({tag, "_alu_rhs"}, alu_rhs, 8'h00);
      check8({tag, "_busy"}, {7'b0, busy}, 8'h00);
      check8({tag, "_halted"}, {7'b0, halted}, 8'h00);
   endtask

   // Pulses start, then counts busy cycles until halted; poke>=0 re-pulses start mid-run.
   task automatic run_prog(input int poke, output int nbusy);
      bit done = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         start = (i == poke);
         if (halted === 1'b1) done = 1'b1;
         else if (busy === 1'b1) nbusy++;
      end
      start = 1'b0;
      check8("run_reaches_halt", {7'b0, done}, 8'h01);
   endtask

   initial begin : main
      int         nb;
      logic [7:0] v;
      logic [1:0] last;
      int         k;
      int         pulses;
      rst = 1'b1; start = 1'b0; start2 = 1'b0; dbg_sel = 2'd0; dbg_sel2 = 2'd1;
      rom2[0] = 8'hF0; rom2[1] = 8'h11; rom2[2] = 8'h00; rom2[3] = 8'h40;
      load_prog(0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
      check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00);

      // Basic program: r2 = 5 + 3
      dbg_sel = 2'd2;
      sbq.push_back('{8'h02, 8'h05, 8'h03, 1'b1, 8'h00, 8'h08});
      run_prog(-1, nb);
      check_int("basic_busy_cycles", nb, 15);
      check8("basic_halted", {7'b0, halted}, 8'h01);
      check_regs("basic", 8'h05, 8'h03, 8'h08, 8'h00);

      // Restart from HALT, with a start pulse while busy that must be ignored
      dbg_sel = 2'd2;
      sbq.push_back('{8'h02, 8'h05, 8'h03, 1'b1, 8'h08, 8'h08});
      run_prog(5, nb);
      check_int("restart_busy_cycles", nb, 15);
      check_regs("restart", 8'h05, 8'h03, 8'h08, 8'h00);

      // Overflow with dst == lhs: FF + 02 = 01
      load_prog(1);
      do_reset();
      dbg_sel = 2'd0;
      sbq.push_back('{8'h02, 8'hFF, 8'h02, 1'b1, 8'hFF, 8'h01});
      run_prog(-1, nb);
      check_int("overflow_busy_cycles", nb, 15);
      check_regs("overflow", 8'h01, 8'h02, 8'h00, 8'h00);

      // Pass-through opcodes 00 and 01
      load_prog(2);
      do_reset();
      dbg_sel = 2'd3;
      sbq.push_back('{8'h00, 8'hAA, 8'h55, 1'b1, 8'h00, 8'hAA});
      sbq.push_back('{8'h01, 8'hAA, 8'h55, 1'b0, 8'h00, 8'h00});
      run_prog(-1, nb);
      check_int("pass_busy_cycles", nb, 21);
      check_regs("pass", 8'hAA, 8'h55, 8'h55, 8'hAA);

      // Reset during WAIT discards the pending writeback
      load_prog(0);
      do_reset();
      dbg_sel = 2'd2;
      sbq.push_back('{8'h02, 8'h05, 8'h03, 1'b0, 8'h00, 8'h00});
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      k = 0;
      while (k < 100 && alu_enable !== 1'b1) begin
         @(negedge clk);
         k++;
      end
      check8("wait_enable_seen", {7'b0, alu_enable}, 8'h01);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst_in_wait");
      check_regs("rst_in_wait", 8'h00, 8'h00, 8'h00, 8'h00);
      repeat (6) @(negedge clk);
      check8("rst_in_wait_still_idle", {7'b0, busy}, 8'h00);
      read_reg(2'd2, v);
      check8("rst_in_wait_no_late_write", v, 8'h00);
      check_int("scoreboard_drained", sbq.size(), 0);

      // PC_W=2 wrap: address changes 1,2,3,0,1,2,3,0 and ALU op repeats
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      last = prog_addr2;
      k = 0;
      pulses = 0;
      for (int i = 0; i < 200 && k < 8; i++) begin
         @(negedge clk);
         if (alu_enable2 === 1'b1) begin
            pulses++;
            check8("wrap_opcode", alu_opcode2, 8'h00);
            check8("wrap_lhs", alu_lhs2, 8'h11);
         end
         if (prog_addr2 !== last) begin
            check8("wrap_prog_addr", {6'b0, prog_addr2}, 8'((k + 1) % 4));
            last = prog_addr2;
            k++;
         end
      end
      check_int("wrap_addr_changes", k, 8);
      check_int("wrap_alu_pulses", pulses, 2);
      dbg_sel2 = 2'd1;
      #1 check8("wrap_r1", dbg_data2, 8'h11);
      dbg_sel2 = 2'd0;
      #1 check8("wrap_r0", dbg_data2, 8'h11);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule : tb_alu_sequencer
`default_nettype wire
